// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Definitions shared by the memory-port arbiter and the pipeline/hazard code:
//   the arbiter FSM state encoding, the default bus widths and the default
//   watchdog limit, plus a helper that sizes the watchdog counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  // The watchdog counts 0 .. timeout-1, so it needs clog2(timeout) bits.
  // A disabled or degenerate watchdog still gets a 1-bit counter.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
//   Watchdog counter for one external memory access.
//   Ports:
//     clk, rstn  - clock, asynchronous active-low reset
//     clr_i      - return the count to zero (no access, or access completing)
//     en_i       - an access is in flight; count one cycle
//     expired_o  - this is the TIMEOUT-th cycle of the access (never set
//                  when TIMEOUT == 0)
module mem_timeout_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned    CW   = tmo_cnt_w(TIMEOUT);
  // Count value during the last permitted cycle of an access.
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch and the MEM
//   stage. One access at a time; data wins over fetch because it belongs to
//   the older instruction. Each completed result is held (with a served flag)
//   until the pipeline advances, and mem_done tells the hazard unit whether
//   every pending request has been served.
//
//   Ports:
//     clk, rstn                  - clock, asynchronous active-low reset
//     if_req, if_addr, if_rdata  - fetch request / PC / captured instruction
//     d_req, d_we, d_addr,
//     d_wdata, d_rdata           - MEM-stage load/store and captured load data
//     pipe_advance               - pipeline registers update at this edge
//     mem_done                   - all pending requests served (0 = freeze)
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_rdata,
//     mem_ack                    - external memory handshake
//     err                        - sticky watchdog timeout flag
//     dbg_state                  - current FSM state (arb_state_e encoding)
//
//   External handshake: mem_req rises with mem_we/mem_addr/mem_wdata and all
//   four stay stable until the memory returns a one-cycle mem_ack (mem_rdata
//   valid in that cycle). mem_req then drops for at least one cycle before the
//   next access. An ack seen while no access is in flight is ignored.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              pipe_advance,
  output logic              mem_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic [1:0]        dbg_state
);

  arb_state_e        state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_srv_q, i_srv_d;
  logic              d_srv_q, d_srv_d;
  logic              err_q, err_d;

  logic busy;
  logic ack_hit;
  logic tmo_expired;
  logic tmo_hit;
  logic finish;
  logic start_data;
  logic start_inst;

  assign busy    = (state_q != ST_IDLE);
  assign ack_hit = busy & mem_ack;
  // A real ack in the expiry cycle wins: the data is genuine.
  assign tmo_hit = busy & tmo_expired & ~mem_ack;
  assign finish  = ack_hit | tmo_hit;

  // At a pipe_advance edge the visible requests still belong to the departing
  // instructions, so nothing is started; the new ones are arbitrated next cycle.
  assign start_data = (state_q == ST_IDLE) & ~pipe_advance & d_req & ~d_srv_q;
  assign start_inst = (state_q == ST_IDLE) & ~pipe_advance & ~start_data &
                      if_req & ~i_srv_q;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (~busy | mem_ack),
    .en_i      (busy),
    .expired_o (tmo_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_data) begin
          state_d = ST_DATA;
        end else if (start_inst) begin
          state_d = ST_INST;
        end
      end
      ST_DATA, ST_INST: begin
        if (finish) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_srv_d     = i_srv_q;
    d_srv_d     = d_srv_q;
    err_d       = err_q;

    if (start_data) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (start_inst) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
    end

    // A timed-out access is reported as served with zero data so the
    // pipeline is never frozen forever; err records that it happened.
    if (finish) begin
      mem_req_d = 1'b0;
      if (state_q == ST_DATA) begin
        d_srv_d = 1'b1;
        if (!mem_we_q) begin
          d_rdata_d = ack_hit ? mem_rdata : '0;
        end
      end else if (state_q == ST_INST) begin
        i_srv_d    = 1'b1;
        if_rdata_d = ack_hit ? mem_rdata : '0;
      end
      if (tmo_hit) begin
        err_d = 1'b1;
      end
    end

    // Clearing wins over a completion in the same cycle: that result belongs
    // to an instruction that has already left the stage.
    if (pipe_advance) begin
      i_srv_d = 1'b0;
      d_srv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      i_srv_q     <= 1'b0;
      d_srv_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_srv_q     <= i_srv_d;
      d_srv_q     <= d_srv_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign mem_done = (~d_req | d_srv_q) & (~if_req | i_srv_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives the arbiter through directed scenarios and randomized
//   instruction steps. The reference is transaction level: each step lists
//   the accesses it must cause (data before fetch), a memory model supplies
//   read data, and captured results / mem_done follow from which accesses
//   have completed.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          if_req, d_req, d_we, pipe_advance, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_done, mem_req, mem_we, err;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .pipe_advance (pipe_advance),
    .mem_done     (mem_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Expected access: {is_inst, we, addr, wdata}
  logic [65:0] exp_q[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_d_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one instruction's requests at the current negedge and queues the
  // accesses it implies: the data access (older instruction) goes first.
  task automatic start_step(input logic dq, input logic we, input logic [AW-1:0] da,
                            input logic [DW-1:0] wd, input logic iq, input logic [AW-1:0] ia);
    d_req = dq; d_we = we; d_addr = da; d_wdata = wd;
    if_req = iq; if_addr = ia;
    if (dq) exp_q.push_back({1'b0, we, da, wd});
    if (iq) exp_q.push_back({1'b1, 1'b0, ia, {DW{1'b0}}});
  endtask

  // Plays the memory for the next expected access: checks latency, the
  // presented command, that it is held for k cycles, then acks once.
  task automatic serve(input int exp_wait, input int k, input string tag);
    logic [65:0]   e;
    logic [DW-1:0] rd;
    int waited;
    e = exp_q.pop_front();
    waited = 0;
    while (mem_req !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".latency"}, waited, exp_wait);
    chk({tag, ".we"}, mem_we, e[64]);
    chk({tag, ".addr"}, mem_addr, e[63:32]);
    if (e[64]) chk({tag, ".wdata"}, mem_wdata, e[31:0]);
    chk({tag, ".state"}, dbg_state, e[65] ? 2'd2 : 2'd1);
    chk({tag, ".done_lo"}, mem_done, 1'b0);
    for (int c = 1; c < k; c++) begin
      @(negedge clk);
      chk({tag, ".req_held"}, mem_req, 1'b1);
      chk({tag, ".addr_held"}, mem_addr, e[63:32]);
      chk({tag, ".done_held"}, mem_done, 1'b0);
    end
    if (e[64]) begin
      mem_model[e[63:32]] = e[31:0];
      rd = $urandom;              // junk on the bus; must not be captured
    end else begin
      rd = model_read(e[63:32]);
      if (e[65]) exp_if_rdata = rd;
      else       exp_d_rdata  = rd;
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    chk({tag, ".req_drop"}, mem_req, 1'b0);
    chk({tag, ".if_rdata"}, if_rdata, exp_if_rdata);
    chk({tag, ".d_rdata"}, d_rdata, exp_d_rdata);
    chk({tag, ".done"}, mem_done, (exp_q.size() == 0) ? 1'b1 : 1'b0);
  endtask

  // Idle cycles with requests still up: nothing re-issued, results stable.
  task automatic hold(input int n, input logic stray_ack, input string tag);
    for (int c = 0; c < n; c++) begin
      if (stray_ack && c == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, ".hold_req"}, mem_req, 1'b0);
      chk({tag, ".hold_done"}, mem_done, 1'b1);
      chk({tag, ".hold_if"}, if_rdata, exp_if_rdata);
      chk({tag, ".hold_d"}, d_rdata, exp_d_rdata);
    end
  endtask

  // One pipe_advance pulse; nothing may start at that edge.
  task automatic advance(input string tag);
    pipe_advance = 1'b1;
    @(negedge clk);
    pipe_advance = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    chk({tag, ".adv_no_start"}, mem_req, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    logic dq, iq, we;
    rstn = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; pipe_advance = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    exp_if_rdata = '0;
    exp_d_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_addr", mem_addr, '0);
    chk("rst.mem_wdata", mem_wdata, '0);
    chk("rst.if_rdata", if_rdata, '0);
    chk("rst.d_rdata", d_rdata, '0);
    chk("rst.err", err, 1'b0);
    chk("rst.state", dbg_state, 2'd0);
    chk("rst.done", mem_done, 1'b1);
    rstn = 1'b1;
    @(negedge clk);

    // IF only: ack after 3 cycles of mem_req
    mem_model[32'h40] = 32'h0010_0093;
    start_step(0, 0, '0, '0, 1, 32'h40);
    #1 chk("if_only.done_n0", mem_done, 1'b0);
    serve(1, 3, "if_only");
    chk("if_only.insn", if_rdata, 32'h0010_0093);
    advance("if_only");

    // Both pending: load 0x100 then fetch 0x44 after one idle cycle
    start_step(1, 0, 32'h100, '0, 1, 32'h44);
    serve(1, 2, "both.data");
    serve(1, 2, "both.inst");

    // Hold with requests asserted, one stray ack in IDLE
    hold(5, 1'b1, "hold");

    // Advance with a new fetch address: mem_req two cycles later
    pipe_advance = 1'b1;
    if_addr = 32'h48;
    d_req = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'h48, {DW{1'b0}}});
    @(negedge clk);
    pipe_advance = 1'b0;
    chk("hold.adv_no_start", mem_req, 1'b0);
    serve(1, 1, "hold.next");
    advance("hold.next");

    // Store: d_rdata keeps the previous load value
    start_step(1, 1, 32'h200, 32'hDEAD_BEEF, 0, '0);
    serve(1, 2, "store");
    chk("store.d_rdata_kept", d_rdata, exp_d_rdata);
    advance("store");

    // Randomized instruction steps
    for (int s = 0; s < 40; s++) begin
      dq = 1'($urandom_range(0, 1));
      iq = 1'($urandom_range(0, 1));
      if (!dq && !iq) iq = 1'b1;
      we = 1'($urandom_range(0, 1));
      start_step(dq, we, {22'd0, 8'($urandom_range(0, 63)), 2'b00}, $urandom,
                 iq, {22'd0, 8'($urandom_range(0, 63)), 2'b00});
      while (exp_q.size() > 0) serve(1, $urandom_range(1, 4), "rand");
      hold($urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
      advance("rand");
    end

    // Watchdog: load with no ack
    start_step(1, 0, 32'h300, '0, 0, '0);
    void'(exp_q.pop_back());
    waited = 0;
    while (mem_req !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("tmo.latency", waited, 1);
    for (int c = 1; c < TMO; c++) begin
      @(negedge clk);
      chk("tmo.req_held", mem_req, 1'b1);
      chk("tmo.err_lo", err, 1'b0);
    end
    @(negedge clk);
    exp_d_rdata = '0;
    chk("tmo.req_drop", mem_req, 1'b0);
    chk("tmo.err", err, 1'b1);
    chk("tmo.d_rdata", d_rdata, '0);
    chk("tmo.done", mem_done, 1'b1);
    chk("tmo.state", dbg_state, 2'd0);
    hold(3, 1'b0, "tmo");
    advance("tmo");
    start_step(0, 0, '0, '0, 1, 32'h80);
    serve(1, 2, "tmo.after");
    chk("tmo.err_sticky", err, 1'b1);
    advance("tmo.after");

    // Reset in the middle of a fetch
    start_step(0, 0, '0, '0, 1, 32'hC0);
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("rst_mid.req_up", mem_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid.req", mem_req, 1'b0);
    chk("rst_mid.state", dbg_state, 2'd0);
    chk("rst_mid.err", err, 1'b0);
    chk("rst_mid.addr", mem_addr, '0);
    chk("rst_mid.if_rdata", if_rdata, '0);
    chk("rst_mid.d_rdata", d_rdata, '0);
    chk("rst_mid.done", mem_done, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("rst_mid.done_idle", mem_done, 1'b1);
    chk("rst_mid.req_idle", mem_req, 1'b0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
